load_store_unit: RTL

Multicycle load/store unit between the core's control FSM and the unified instruction/data memory. It accepts one RV32I load or store request at a time and drives a word-aligned, byte-enabled memory port with a req/ready handshake. Load results are returned sign- or zero-extended. Misaligned accesses and memory timeouts are reported as errors. The block lets the memory stage tolerate variable-latency memory, replacing the direct single-cycle memory hookup.

---
 rtl/load_store_unit.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one RV32I load or store at a time and drives a
// word-aligned, byte-enabled memory port with a req/ready handshake.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; all memory outputs inactive
// REQ   | mem_req high, waiting for mem_ready or wait-budget expiry
// DONE  | one-cycle completion pulse, fault reported if budget expired
// ERR   | one-cycle completion pulse for misaligned/illegal access
module load_store_unit #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  lo_q, lo_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        fault_q, fault_d;
    logic [31:0] rdata_q, rdata_d;

    logic        req_bad;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_val;
    logic [7:0]  cnt_inc;

    assign cnt_inc = cnt_q + 8'd1;

    // Decode the incoming request: legality, byte lanes and replicated store data.
    always_comb begin
        req_bad   = 1'b0;
        req_be    = 4'b0000;
        req_wdata = wdata;
        case (funct3)
            3'b000, 3'b100: begin
                req_be    = 4'b0001 << addr[1:0];
                req_wdata = {4{wdata[7:0]}};
                req_bad   = we & funct3[2];
            end
            3'b001, 3'b101: begin
                req_be    = addr[1] ? 4'b1100 : 4'b0011;
                req_wdata = {2{wdata[15:0]}};
                req_bad   = addr[0] | (we & funct3[2]);
            end
            3'b010: begin
                req_be    = 4'b1111;
                req_wdata = wdata;
                req_bad   = addr[1] | addr[0];
            end
            default: req_bad = 1'b1;
        endcase
    end

    // Extract and extend the load result from the lane chosen by the latched offset.
    always_comb begin
        case (lo_q)
            2'd0:    lane_byte = mem_rdata[7:0];
            2'd1:    lane_byte = mem_rdata[15:8];
            2'd2:    lane_byte = mem_rdata[23:16];
            default: lane_byte = mem_rdata[31:24];
        endcase
        lane_half = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_val = {{24{lane_byte[7]}}, lane_byte};
            3'b100:  load_val = {24'd0, lane_byte};
            3'b001:  load_val = {{16{lane_half[15]}}, lane_half};
            3'b101:  load_val = {16'd0, lane_half};
            default: load_val = mem_rdata;
        endcase
    end

    // Next-state logic and latching of the accepted request.
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        lo_d     = lo_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        fault_d  = fault_q;
        rdata_d  = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (req_bad) begin
                        state_d = S_ERR;
                    end else begin
                        state_d  = S_REQ;
                        we_d     = we;
                        funct3_d = funct3;
                        lo_d     = addr[1:0];
                        addr_d   = {addr[31:2], 2'b00};
                        be_d     = req_be;
                        wdata_d  = req_wdata;
                        cnt_d    = 8'd0;
                        fault_d  = 1'b0;
                    end
                end
            end
            S_REQ: begin
                if (mem_ready) begin
                    if (!we_q) begin
                        rdata_d = load_val;
                    end
                    fault_d = 1'b0;
                    state_d = S_DONE;
                end else begin
                    // A ready in the last budgeted cycle still wins over the fault.
                    cnt_d = cnt_inc;
                    if (cnt_inc >= MAX_WAIT_C) begin
                        fault_d = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            lo_q     <= 2'd0;
            addr_q   <= 32'd0;
            be_q     <= 4'd0;
            wdata_q  <= 32'd0;
            cnt_q    <= 8'd0;
            fault_q  <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            lo_q     <= lo_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            fault_q  <= fault_d;
            rdata_q  <= rdata_d;
        end
    end

    // Outputs decode straight from state so reset removes mem_req immediately.
    always_comb begin
        busy       = (state_q != S_IDLE);
        done       = (state_q == S_DONE) || (state_q == S_ERR);
        misaligned = (state_q == S_ERR);
        fault      = (state_q == S_DONE) && fault_q;
        mem_req    = (state_q == S_REQ);
        mem_we     = we_q && (state_q == S_REQ);
        mem_addr   = addr_q;
        mem_be     = be_q;
        mem_wdata  = wdata_q;
        rdata      = rdata_q;
    end

endmodule
